// File: rtl/deser_link_pkg.sv
// Shared link definitions: FSM state encoding and the special 10-bit control words
// used by both the receive-side and transmit-side link controllers.
package deser_link_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        WAIT_TAIL = 2'd1,
        NORMAL    = 2'd2
    } link_state_e;

    localparam logic [9:0] TAIL_WORD = 10'b10011_11100;
    localparam logic [9:0] IDLE_WORD = 10'b00000_11111;

endpackage

// File: rtl/deser_link_ctrl_lock_filter.sv
// Consecutive-lock counter: stable is asserted in the cycle that completes a run of
// LOCK_STABLE lock-high samples. Any low sample or an active clear restarts the run.
module lock_filter #(
    parameter int unsigned LOCK_STABLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic lock,
    input  logic clear,
    output logic stable
);

    localparam int unsigned CW = $clog2(LOCK_STABLE + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !lock) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(LOCK_STABLE)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stable = (cnt_d == CW'(LOCK_STABLE));

endmodule

// File: rtl/deser_link_ctrl.sv
// Receive-side link controller: waits for stable lock, hunts for TAIL_WORD, then forwards
// non-idle payload words. Optional RxWordCnt output is built when DERX_WORD_CNT_EN is defined.
module deser_link_ctrl
    import deser_link_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned TAIL_TIMEOUT = 2047
) (
    input  logic        CLK_10MHZ,
    input  logic        Rst,
    input  logic        UpSig_Lock,
    input  logic [9:0]  UpSig_Dout,
    output logic        sync_success,
    output logic [9:0]  DataOut,
    output logic        DataOutEn,
`ifdef DERX_WORD_CNT_EN
    output logic [15:0] RxWordCnt,
`endif
    output logic        link_err
);

    // Timeout fires on the TAIL_TIMEOUT-th cycle spent in WAIT_TAIL.
    localparam logic [10:0] TMO_LAST = 11'(TAIL_TIMEOUT - 1);

    link_state_e state_q, state_d;
    logic [10:0] tmo_q, tmo_d;
    logic [9:0]  data_q, data_d;
    logic        en_q, en_d;
    logic        err_q, err_d;
    logic        sync_q;
    logic        lock_stable;

    lock_filter #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_filter (
        .clk    (CLK_10MHZ),
        .rst    (Rst),
        .lock   (UpSig_Lock),
        .clear  (state_q != WAIT_LOCK),
        .stable (lock_stable)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        data_d  = data_q;
        en_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_stable) state_d = WAIT_TAIL;
            end
            WAIT_TAIL: begin
                // Lock loss outranks both tail detection and timeout.
                if (!UpSig_Lock) begin
                    state_d = WAIT_LOCK;
                end else if (UpSig_Dout == TAIL_WORD) begin
                    state_d = NORMAL;
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = WAIT_LOCK;
                    err_d   = 1'b1;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 11'd1;
                end else begin
                    tmo_d = tmo_q;
                end
            end
            NORMAL: begin
                if (!UpSig_Lock) begin
                    state_d = WAIT_LOCK;
                    err_d   = 1'b1;
                end else if (UpSig_Dout != IDLE_WORD) begin
                    data_d = UpSig_Dout;
                    en_d   = 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (Rst) begin
            state_q <= WAIT_LOCK;
            tmo_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            en_q    <= en_d;
            err_q   <= err_d;
            sync_q  <= (state_d == NORMAL);
        end
    end

`ifdef DERX_WORD_CNT_EN
    logic [15:0] word_cnt_q;

    // Counts forwarded words across resyncs; only reset clears it.
    always_ff @(posedge CLK_10MHZ) begin
        if (Rst) begin
            word_cnt_q <= '0;
        end else if (en_d) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign RxWordCnt = word_cnt_q;
`endif

    assign sync_success = sync_q;
    assign DataOut      = data_q;
    assign DataOutEn    = en_q;
    assign link_err     = err_q;

endmodule

// File: tb/tb_deser_link_ctrl.sv
// Directed and randomized bench for deser_link_ctrl with a behavioural reference model.
module tb_deser_link_ctrl;
    import deser_link_pkg::*;

    localparam int LOCK_STABLE  = 16;
    localparam int TAIL_TIMEOUT = 2047;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic [9:0] dout = '0;
    logic       sync_success, data_en, link_err;
    logic [9:0] data_out;
`ifdef DERX_WORD_CNT_EN
    logic [15:0] rx_cnt;
`endif

    always #50 clk = ~clk;

    deser_link_ctrl #(
        .LOCK_STABLE (LOCK_STABLE),
        .TAIL_TIMEOUT(TAIL_TIMEOUT)
    ) dut (
        .CLK_10MHZ   (clk),
        .Rst         (rst),
        .UpSig_Lock  (lock),
        .UpSig_Dout  (dout),
        .sync_success(sync_success),
        .DataOut     (data_out),
        .DataOutEn   (data_en),
`ifdef DERX_WORD_CNT_EN
        .RxWordCnt   (rx_cnt),
`endif
        .link_err    (link_err)
    );

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    // Reference model: lock-run length, time spent hunting for the tail, and link status.
    bit          m_hunting;
    bit          m_linked;
    int          m_run;
    int          m_hunt_len;
    logic [9:0]  m_data;
    bit          m_en;
    bit          m_err;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
    endtask

    function automatic void model_step(input bit r, input bit l, input logic [9:0] d);
        m_en  = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_hunting = 1'b0; m_linked = 1'b0; m_run = 0; m_hunt_len = 0;
            m_data = '0; m_cnt = '0;
        end else if (m_linked) begin
            if (!l) begin
                m_linked = 1'b0; m_run = 0; m_err = 1'b1;
            end else if (d != IDLE_WORD) begin
                m_data = d; m_en = 1'b1; m_cnt = m_cnt + 16'd1;
            end
        end else if (m_hunting) begin
            if (!l) begin
                m_hunting = 1'b0; m_run = 0;
            end else if (d == TAIL_WORD) begin
                m_hunting = 1'b0; m_linked = 1'b1;
            end else begin
                m_hunt_len++;
                if (m_hunt_len == TAIL_TIMEOUT) begin
                    m_hunting = 1'b0; m_run = 0; m_err = 1'b1;
                end
            end
        end else begin
            m_run = l ? m_run + 1 : 0;
            if (m_run == LOCK_STABLE) begin
                m_hunting = 1'b1; m_hunt_len = 0; m_run = 0;
            end
        end
    endfunction

    task automatic cyc(input bit r, input bit l, input logic [9:0] d);
        rst = r; lock = l; dout = d;
        @(posedge clk);
        model_step(r, l, d);
        cycle++;
        #1;
        chk("model_sync", 16'(sync_success), 16'(m_linked));
        chk("model_data", 16'(data_out), 16'(m_data));
        chk("model_en",   16'(data_en), 16'(m_en));
        chk("model_err",  16'(link_err), 16'(m_err));
`ifdef DERX_WORD_CNT_EN
        chk("model_cnt",  rx_cnt, m_cnt);
`endif
    endtask

    function automatic logic [9:0] non_tail();
        logic [9:0] w;
        w = 10'($urandom_range(0, 1023));
        if (w == TAIL_WORD) w = IDLE_WORD;
        return w;
    endfunction

    initial begin
        bit saw_en;
        bit saw_err;
        bit rr, ll;
        logic [9:0] dd;
        int sel;

        // Reset held with lock already high.
        repeat (3) cyc(1, 1, TAIL_WORD);
        chk("rst_sync", 16'(sync_success), 16'd0);
        chk("rst_data", 16'(data_out), 16'd0);
        chk("rst_en",   16'(data_en), 16'd0);
        chk("rst_err",  16'(link_err), 16'd0);

        // Stable lock, long run of sync words, then the tail.
        repeat (LOCK_STABLE) cyc(0, 1, 10'h17C);
        saw_en = 1'b0;
        for (int i = 0; i < 1026; i++) begin
            cyc(0, 1, (i % 3 == 0) ? 10'h000 : (((i % 2) != 0) ? 10'h17C : 10'h283));
            saw_en |= data_en;
        end
        chk("sync_before_tail", 16'(sync_success), 16'd0);
        cyc(0, 1, TAIL_WORD);
        chk("sync_after_tail", 16'(sync_success), 16'd1);
        chk("no_en_during_sync", 16'(saw_en | data_en), 16'd0);

        // Payload forwarding with an idle in between; tail forwarded as payload.
        cyc(0, 1, 10'h155);
        chk("pay1_en", 16'(data_en), 16'd1);
        chk("pay1_data", 16'(data_out), 16'h155);
        cyc(0, 1, IDLE_WORD);
        chk("idle_en", 16'(data_en), 16'd0);
        chk("idle_hold", 16'(data_out), 16'h155);
        cyc(0, 1, 10'h27C);
        chk("pay2_en", 16'(data_en), 16'd1);
        chk("pay2_data", 16'(data_out), 16'h27C);
        cyc(0, 1, TAIL_WORD);
        chk("tail_payload", 16'(data_out), 16'(TAIL_WORD));

        // Lock loss during a payload word, then resync.
        cyc(0, 0, 10'h2AA);
        chk("loss_err", 16'(link_err), 16'd1);
        chk("loss_sync", 16'(sync_success), 16'd0);
        chk("loss_en", 16'(data_en), 16'd0);
        chk("loss_drop", 16'(data_out), 16'(TAIL_WORD));
        cyc(0, 1, 10'h2AA);
        chk("loss_err_pulse", 16'(link_err), 16'd0);
        repeat (LOCK_STABLE - 1) cyc(0, 1, 10'h17C);
        cyc(0, 1, TAIL_WORD);
        chk("resync", 16'(sync_success), 16'd1);

        // Reset in NORMAL with a word in flight.
        cyc(0, 1, 10'h155);
        cyc(1, 1, 10'h2AA);
        chk("rstn_sync", 16'(sync_success), 16'd0);
        chk("rstn_data", 16'(data_out), 16'd0);
        chk("rstn_en", 16'(data_en), 16'd0);
        chk("rstn_err", 16'(link_err), 16'd0);
`ifdef DERX_WORD_CNT_EN
        chk("rstn_cnt", rx_cnt, 16'd0);
`endif

        // Stability count restarts after reset: 16th high sample enters tail search.
        repeat (LOCK_STABLE - 1) cyc(0, 1, TAIL_WORD);
        cyc(0, 1, TAIL_WORD);
        chk("restart_no_early_sync", 16'(sync_success), 16'd0);
        cyc(0, 1, TAIL_WORD);
        chk("restart_sync", 16'(sync_success), 16'd1);

        // Lock glitch on the 15th stability cycle.
        cyc(1, 1, 10'h17C);
        repeat (14) cyc(0, 1, 10'h17C);
        cyc(0, 0, 10'h17C);
        repeat (LOCK_STABLE - 1) cyc(0, 1, TAIL_WORD);
        cyc(0, 1, TAIL_WORD);
        chk("glitch_no_sync", 16'(sync_success), 16'd0);
        cyc(0, 1, TAIL_WORD);
        chk("glitch_sync", 16'(sync_success), 16'd1);

        // Lock loss during tail search: silent return to WAIT_LOCK.
        cyc(1, 1, 10'h17C);
        repeat (LOCK_STABLE) cyc(0, 1, 10'h17C);
        repeat (5) cyc(0, 1, 10'h283);
        cyc(0, 0, 10'h17C);
        chk("hunt_loss_err", 16'(link_err), 16'd0);
        cyc(0, 1, TAIL_WORD);
        chk("hunt_loss_sync", 16'(sync_success), 16'd0);

        // Tail timeout.
        cyc(1, 1, 10'h17C);
        repeat (LOCK_STABLE) cyc(0, 1, 10'h17C);
        saw_err = 1'b0;
        for (int i = 0; i < TAIL_TIMEOUT - 1; i++) begin
            cyc(0, 1, non_tail());
            saw_err |= link_err;
        end
        chk("tmo_no_early_err", 16'(saw_err), 16'd0);
        cyc(0, 1, 10'h17C);
        chk("tmo_err", 16'(link_err), 16'd1);
        chk("tmo_sync", 16'(sync_success), 16'd0);
        cyc(0, 1, TAIL_WORD);
        chk("tmo_err_pulse", 16'(link_err), 16'd0);
        chk("tmo_back_to_lock", 16'(sync_success), 16'd0);

        // Timeout and lock loss in the same cycle: lock loss wins, no error.
        cyc(1, 1, 10'h17C);
        repeat (LOCK_STABLE) cyc(0, 1, 10'h17C);
        for (int i = 0; i < TAIL_TIMEOUT - 1; i++) cyc(0, 1, non_tail());
        cyc(0, 0, 10'h17C);
        chk("tmo_vs_loss_err", 16'(link_err), 16'd0);

        // Randomized traffic against the model.
        cyc(1, 0, 10'h000);
        for (int i = 0; i < 4000; i++) begin
            rr  = ($urandom_range(0, 999) == 0);
            ll  = ($urandom_range(0, 63) != 0);
            sel = $urandom_range(0, 7);
            dd  = (sel == 0) ? TAIL_WORD : (sel == 1) ? IDLE_WORD : 10'($urandom_range(0, 1023));
            cyc(rr, ll, dd);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
